// File: rtl/fast_square_pkg.sv
// Shared definitions for the fast-square baseband packer/unpacker pair.
//   MARKER_WORD        : restart-marker value carried on both I and Q
//   WORD_BITS          : samples per packed word
//   DEFAULT_MIN_MARKER : consecutive markers needed to declare a restart
//   state_t            : receive framing state
package fast_square_pkg;

  localparam logic [15:0] MARKER_WORD        = 16'h8000;
  localparam int          WORD_BITS          = 16;
  localparam int          DEFAULT_MIN_MARKER = 16;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/fast_square_word_fifo.sv
// Two-entry word FIFO holding one packed I/Q pair per entry.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   flush          : empties the FIFO, overriding push/pop
//   push, wdata    : write request and {I, Q} data; ignored when full unless
//                    a pop happens in the same cycle
//   pop            : read request; rdata shows the head entry combinationally
//   full, empty    : occupancy flags
module fast_square_word_fifo
  import fast_square_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [2*WORD_BITS-1:0]   wdata,
  output logic [2*WORD_BITS-1:0]   rdata,
  output logic                     full,
  output logic                     empty
);

  logic [2*WORD_BITS-1:0] mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written, so a full FIFO
  // can still accept a word.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count decide
  // what is valid, and leaving the data unreset keeps it a plain RAM.
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fast_square_unpack.sv
// Receive-side unpacker for the 1-bit "fast square" baseband stream.
// Hunts for a run of 0x8000/0x8000 restart markers, then serializes each
// packed word MSB-first, one I and one Q bit per clock, as +/-AMP samples.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   in_strobe, i_in, q_in : strobed packed words (bit 15 = oldest sample)
//   out_valid             : i_bit/q_bit/i_sample/q_sample valid this cycle
//   i_bit, q_bit          : current serialized bits
//   i_sample, q_sample    : signed +AMP (bit 1) / -AMP (bit 0), held when idle
//   locked                : high while in DATA
//   restart_pulse         : one cycle, in the cycle after each SYNC->DATA entry
//   overflow              : sticky, a word arrived with the FIFO full
//   word_count            : data words accepted since the last lock
module fast_square_unpack
  import fast_square_pkg::*;
#(
  parameter int                            MIN_MARKER = DEFAULT_MIN_MARKER,
  parameter logic signed [WORD_BITS-1:0]   AMP        = 16'sd8192
)(
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_strobe,
  input  logic [WORD_BITS-1:0]        i_in,
  input  logic [WORD_BITS-1:0]        q_in,
  output logic                        out_valid,
  output logic                        i_bit,
  output logic                        q_bit,
  output logic signed [WORD_BITS-1:0] i_sample,
  output logic signed [WORD_BITS-1:0] q_sample,
  output logic                        locked,
  output logic                        restart_pulse,
  output logic                        overflow,
  output logic [15:0]                 word_count
);

  localparam int MCNT_W = $clog2(MIN_MARKER + 1);

  state_t              state_q, state_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic                is_marker;
  logic                push;
  logic                flush;
  logic                lock_entry;

  logic [2*WORD_BITS-1:0] fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic                 busy;
  logic [3:0]           bit_cnt;
  logic [WORD_BITS-1:0] sr_i;
  logic [WORD_BITS-1:0] sr_q;
  logic                 last_bit;
  logic                 load;

  assign is_marker = in_strobe && (i_in == MARKER_WORD) && (q_in == MARKER_WORD);
  assign locked    = (state_q == DATA);

  // NOTE: every signal is given a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    mcnt_d     = mcnt_q;
    push       = 1'b0;
    flush      = 1'b0;
    lock_entry = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (in_strobe) begin
          if (!is_marker) begin
            mcnt_d = '0;
          end else if (mcnt_q == MCNT_W'(MIN_MARKER - 1)) begin
            state_d = SYNC;
            mcnt_d  = '0;
          end else begin
            mcnt_d = mcnt_q + MCNT_W'(1);
          end
        end
      end
      SYNC: begin
        if (in_strobe && !is_marker) begin
          state_d    = DATA;
          push       = 1'b1;
          lock_entry = 1'b1;
        end
      end
      DATA: begin
        if (in_strobe) begin
          if (is_marker && mcnt_q == MCNT_W'(MIN_MARKER - 1)) begin
            // Threshold marker: drop lock and discard everything in flight.
            state_d = SYNC;
            mcnt_d  = '0;
            flush   = 1'b1;
          end else begin
            push   = 1'b1;
            mcnt_d = is_marker ? mcnt_q + MCNT_W'(1) : '0;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // The serializer reloads on its final bit when another word is waiting,
  // so continuous 16-cycle strobes produce a gap-free output stream.
  assign last_bit = busy && (bit_cnt == 4'd15);
  assign load     = !flush && !fifo_empty && (!busy || last_bit);

  fast_square_word_fifo u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .pop     (load),
    .wdata   ({i_in, q_in}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= HUNT;
      mcnt_q        <= '0;
      restart_pulse <= 1'b0;
      overflow      <= 1'b0;
      word_count    <= '0;
    end else begin
      state_q       <= state_d;
      mcnt_q        <= mcnt_d;
      restart_pulse <= lock_entry;
      if (push && fifo_full && !load) overflow <= 1'b1;
      if (lock_entry) begin
        word_count <= 16'd1;
      end else if (push && (!fifo_full || load)) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      bit_cnt   <= '0;
      sr_i      <= '0;
      sr_q      <= '0;
      out_valid <= 1'b0;
      i_bit     <= 1'b0;
      q_bit     <= 1'b0;
      i_sample  <= '0;
      q_sample  <= '0;
    end else if (flush) begin
      busy      <= 1'b0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= busy;
      if (busy) begin
        i_bit    <= sr_i[WORD_BITS-1];
        q_bit    <= sr_q[WORD_BITS-1];
        i_sample <= sr_i[WORD_BITS-1] ? AMP : -AMP;
        q_sample <= sr_q[WORD_BITS-1] ? AMP : -AMP;
        sr_i     <= {sr_i[WORD_BITS-2:0], 1'b0};
        sr_q     <= {sr_q[WORD_BITS-2:0], 1'b0};
        bit_cnt  <= bit_cnt + 4'd1;
      end
      if (load) begin
        sr_i    <= fifo_rdata[2*WORD_BITS-1:WORD_BITS];
        sr_q    <= fifo_rdata[WORD_BITS-1:0];
        bit_cnt <= '0;
        busy    <= 1'b1;
      end else if (last_bit) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fast_square_unpack.sv
// Self-checking bench for fast_square_unpack: a behavioural framing model
// predicts the serialized bit stream into a queue; a monitor compares every
// valid output cycle against the queue head.
module tb_fast_square_unpack;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_strobe = 1'b0;
  logic [15:0]        i_in = '0;
  logic [15:0]        q_in = '0;
  logic               out_valid;
  logic               i_bit;
  logic               q_bit;
  logic signed [15:0] i_sample;
  logic signed [15:0] q_sample;
  logic               locked;
  logic               restart_pulse;
  logic               overflow;
  logic [15:0]        word_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_q[$];

  // Framing model: 0 = hunting, 1 = synced awaiting data, 2 = locked.
  int          m_state = 0;
  int          m_run   = 0;
  logic [15:0] m_wc    = '0;

  fast_square_unpack dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_strobe     (in_strobe),
    .i_in          (i_in),
    .q_in          (q_in),
    .out_valid     (out_valid),
    .i_bit         (i_bit),
    .q_bit         (q_bit),
    .i_sample      (i_sample),
    .q_sample      (q_sample),
    .locked        (locked),
    .restart_pulse (restart_pulse),
    .overflow      (overflow),
    .word_count    (word_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] amp_of(input logic b);
    return b ? 16'h2000 : 16'hE000;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("bits_iq", {30'b0, i_bit, q_bit}, {30'b0, e});
        check("i_sample", {16'b0, i_sample}, {16'b0, amp_of(e[1])});
        check("q_sample", {16'b0, q_sample}, {16'b0, amp_of(e[0])});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Strobes one word and waits until the next strobe slot (gap cycles apart).
  // Entered and left at posedge + 1.
  task automatic send_word(input logic [15:0] wi, input logic [15:0] wq,
                           input int gap, input bit lat_chk, input bit drop);
    bit mk;
    bit pushed = 0;
    bit flushed = 0;
    bit restart = 0;
    int used = 1;
    mk = (wi == 16'h8000) && (wq == 16'h8000);
    case (m_state)
      0: begin
        m_run = mk ? m_run + 1 : 0;
        if (m_run == 16) begin m_state = 1; m_run = 0; end
      end
      1: if (!mk) begin m_state = 2; m_run = 0; pushed = 1; restart = 1; m_wc = 16'd1; end
      default: begin
        m_run = mk ? m_run + 1 : 0;
        if (m_run == 16) begin
          m_state = 1; m_run = 0; flushed = 1;
        end else begin
          pushed = 1;
          if (!drop) m_wc = m_wc + 16'd1;
        end
      end
    endcase

    in_strobe = 1'b1; i_in = wi; q_in = wq;
    @(posedge clock);
    #1;
    in_strobe = 1'b0;
    if (flushed) exp_q.delete();
    if (pushed && !drop)
      for (int b = 15; b >= 0; b--) exp_q.push_back({wi[b], wq[b]});
    check("locked", {31'b0, locked}, {31'b0, m_state == 2});
    check("restart_pulse", {31'b0, restart_pulse}, {31'b0, restart});
    if (m_state == 2) check("word_count", {16'b0, word_count}, {16'b0, m_wc});
    if (lat_chk) begin
      tick(1);
      check("latency_idle_k1", {31'b0, out_valid}, 32'd0);
      tick(1);
      check("latency_valid_k2", {31'b0, out_valid}, 32'd1);
      check("latency_first_bit", {31'b0, i_bit}, {31'b0, wi[15]});
      used = 3;
    end
    if (gap > used) tick(gap - used);
  endtask

  task automatic send_markers(input int n, input int gap);
    for (int k = 0; k < n; k++) send_word(16'h8000, 16'h8000, gap, 0, 0);
  endtask

  initial begin
    int lows;
    int run;

    // Reset state
    #23;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_locked", {31'b0, locked}, 32'd0);
    check("reset_word_count", {16'b0, word_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Too few markers: no lock
    send_markers(3, 2);
    send_word(16'hA5A5, 16'h0000, 20, 0, 0);
    check("short_preamble_locked", {31'b0, locked}, 32'd0);

    // 20 markers then a continuous data stream
    send_markers(20, 2);
    send_word(16'hA5A5, 16'h0FF0, 16, 1, 0);
    lows = 0;
    fork
      for (int k = 0; k < 4; k++) send_word(16'hA5A5, 16'h0FF0, 16, 0, 0);
      repeat (56) begin
        @(negedge clock);
        if (!out_valid) lows++;
      end
    join
    check("out_valid_gaps", lows, 32'd0);

    // A single marker pair inside a locked stream is ordinary data
    send_word(16'h8000, 16'h8000, 16, 0, 0);
    send_word(16'h1234, 16'hFEDC, 16, 0, 0);
    check("marker_as_data_locked", {31'b0, locked}, 32'd1);

    // 15 markers keep lock, the 16th drops it; next data relocks
    send_markers(15, 16);
    check("fifteen_markers_locked", {31'b0, locked}, 32'd1);
    send_markers(1, 16);
    check("sixteen_markers_unlocked", {31'b0, locked}, 32'd0);
    send_word(16'h3C3C, 16'hC3C3, 16, 0, 0);
    check("relock_word_count", {16'b0, word_count}, 32'd1);

    // Randomized traffic with marker runs around the threshold
    for (int n = 0; n < 40; n++) begin
      run = $urandom_range(0, 9);
      if (run == 0) begin
        send_markers($urandom_range(12, 18), 16);
      end else if (run == 1) begin
        send_markers(1, 16);
      end else begin
        send_word(16'($urandom), 16'($urandom), 16 + $urandom_range(0, 4), 0, 0);
      end
    end
    send_word(16'h0F0F, 16'hAAAA, 16, 0, 0);
    tick(40);
    check("drain_before_overflow", exp_q.size(), 32'd0);

    // Overflow: three back-to-back strobes while the serializer is busy
    send_word(16'h1111, 16'h2222, 4, 0, 0);
    check("overflow_before", {31'b0, overflow}, 32'd0);
    send_word(16'h3333, 16'h4444, 1, 0, 0);
    send_word(16'h5555, 16'h6666, 1, 0, 0);
    send_word(16'h7777, 16'h9999, 1, 0, 1);
    check("overflow_set", {31'b0, overflow}, 32'd1);
    tick(60);
    check("overflow_sticky", {31'b0, overflow}, 32'd1);
    check("drain_after_overflow", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a word
    send_word(16'hF00F, 16'h0FF0, 6, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_i_sample", {16'b0, i_sample}, 32'd0);
    check("async_rst_locked", {31'b0, locked}, 32'd0);
    check("async_rst_overflow", {31'b0, overflow}, 32'd0);
    check("async_rst_word_count", {16'b0, word_count}, 32'd0);
    exp_q.delete();
    m_state = 0; m_run = 0; m_wc = '0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // After reset, 15 markers are not enough; 16 are
    send_markers(15, 2);
    send_word(16'hBEEF, 16'hCAFE, 2, 0, 0);
    check("post_rst_15_locked", {31'b0, locked}, 32'd0);
    send_markers(16, 2);
    send_word(16'hBEEF, 16'hCAFE, 16, 1, 0);
    check("post_rst_relocked", {31'b0, locked}, 32'd1);
    tick(30);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
